// File: rtl/sha3_scan_job_loader.sv
// Stages one SHA-3 scan job (threshold + block template) from a 32-bit word
// stream and hands it to the scanner with a one-cycle start pulse.
// Optional build macro: SHA3_LOADER_ERRCNT_EN enables the malformed-frame counter.
//
// Handshake: a stream word transfers on any rising clk edge where s_valid and
// s_ready are both high; s_ready depends only on registered state, never on s_valid.
module sha3_scan_job_loader #(
  parameter int PROPER = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      s_valid,
  input  logic [31:0]                               s_data,
  input  logic                                      s_last,
  output logic                                      s_ready,
  input  logic                                      scanner_ready,
  output logic                                      start,
  output logic [63:0]                               threshold,
  output logic [32*((PROPER != 0) ? 20 : 24)-1:0]   blockTemplate,
  output logic                                      job_pending,
  output logic [15:0]                               jobs_issued,
  output logic [7:0]                                err_count
);

  localparam int N = (PROPER != 0) ? 20 : 24;
  localparam int FRAME_WORDS = N + 2;
  localparam logic [4:0] LAST_IDX = 5'(N + 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] stage_q [FRAME_WORDS];
  logic        accept;
  logic        stage_we;
  logic        issue;
  logic        err_inc;

  assign s_ready     = (state_q != PENDING);
  assign job_pending = (state_q == PENDING);
  assign accept      = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stage_we = 1'b0;
    issue    = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          stage_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last) begin
              state_d = PENDING;
            end else begin
              // Over-long frame: discard what is staged and skip to its end.
              state_d = DRAIN;
              err_inc = 1'b1;
            end
          end else if (s_last) begin
            idx_d   = '0;
            err_inc = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      PENDING: begin
        if (scanner_ready && !start) begin
          issue   = 1'b1;
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_WORDS; i++) stage_q[i] <= '0;
    end else if (stage_we) begin
      stage_q[idx_q] <= s_data;
    end
  end

  // Outputs move only on issue, so the scanner sees a stable job for the whole scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start         <= 1'b0;
      threshold     <= '0;
      blockTemplate <= '0;
      jobs_issued   <= '0;
    end else begin
      start <= issue;
      if (issue) begin
        threshold   <= {stage_q[1], stage_q[0]};
        jobs_issued <= jobs_issued + 16'd1;
        for (int k = 0; k < N; k++) blockTemplate[32*k +: 32] <= stage_q[k+2];
      end
    end
  end

`ifdef SHA3_LOADER_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_sha3_scan_job_loader.sv
// Directed bench for sha3_scan_job_loader: one instance per template length
// (PROPER=1 -> 20 words, PROPER=0 -> 24 words) driven from a single sequence.
module tb_sha3_scan_job_loader;

  logic         clk;
  logic         rst_n;
  logic         s_valid20, s_valid24;
  logic [31:0]  s_data;
  logic         s_last;
  logic         s_ready20, s_ready24;
  logic         scanner_ready;
  logic         start20, start24;
  logic [63:0]  threshold20, threshold24;
  logic [639:0] tpl20;
  logic [767:0] tpl24;
  logic         job_pending20, job_pending24;
  logic [15:0]  jobs_issued20, jobs_issued24;
  logic [7:0]   err_count20, err_count24;

  int checks;
  int failures;
  int start_seen20;

  sha3_scan_job_loader #(.PROPER(1)) dut20 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid20), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready20), .scanner_ready(scanner_ready), .start(start20),
    .threshold(threshold20), .blockTemplate(tpl20), .job_pending(job_pending20),
    .jobs_issued(jobs_issued20), .err_count(err_count20)
  );

  sha3_scan_job_loader #(.PROPER(0)) dut24 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid24), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready24), .scanner_ready(scanner_ready), .start(start24),
    .threshold(threshold24), .blockTemplate(tpl24), .job_pending(job_pending24),
    .jobs_issued(jobs_issued24), .err_count(err_count24)
  );

  // Clock and start-pulse monitor.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (start20) start_seen20++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word to the selected instance and returns 1 time unit after it is accepted.
  task automatic send_word(input int sel, input logic [31:0] data, input logic last);
    int waited;
    s_data = data;
    s_last = last;
    if (sel == 0) s_valid20 = 1'b1; else s_valid24 = 1'b1;
    waited = 0;
    while (((sel == 0) ? s_ready20 : s_ready24) !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    if (waited >= 300) chk("ready_timeout", 64'(waited), 64'(0));
    tick();
    s_valid20 = 1'b0;
    s_valid24 = 1'b0;
    s_last    = 1'b0;
  endtask

  task automatic send_frame(input int sel, input int nwords, input int last_at,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] base);
    for (int i = 0; i < nwords; i++) begin
      if (i == 0)      send_word(sel, w0, (i == last_at));
      else if (i == 1) send_word(sel, w1, (i == last_at));
      else             send_word(sel, base + 32'(i), (i == last_at));
    end
  endtask

  initial begin
    logic [7:0] exp_err;
    int seen;
    checks        = 0;
    failures      = 0;
    start_seen20  = 0;
    rst_n         = 1'b0;
    s_valid20     = 1'b0;
    s_valid24     = 1'b0;
    s_data        = '0;
    s_last        = 1'b0;
    scanner_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_start", 64'(start20), 64'(0));
    chk("rst_pending", 64'(job_pending20), 64'(0));
    chk("rst_threshold", threshold20, 64'(0));
    chk("rst_jobs", 64'(jobs_issued20), 64'(0));
    chk("rst_err", 64'(err_count20), 64'(0));
    #3 rst_n = 1'b1;
    tick();
    chk("rst_s_ready", 64'(s_ready20), 64'(1));

    // Scenario 1: 20-word template, scanner idle
    send_frame(0, 22, 21, 32'h0000FFFF, 32'h0, 32'h0);
    chk("s1_start_e0", 64'(start20), 64'(0));
    chk("s1_pending_e0", 64'(job_pending20), 64'(1));
    tick();
    chk("s1_start_e1", 64'(start20), 64'(1));
    chk("s1_threshold", threshold20, 64'h0000_0000_0000_FFFF);
    chk("s1_jobs", 64'(jobs_issued20), 64'(1));
    chk("s1_pending_e1", 64'(job_pending20), 64'(0));
    for (int k = 0; k < 20; k++) chk($sformatf("s1_tpl%0d", k), 64'(tpl20[32*k +: 32]), 64'(k + 2));
    tick();
    chk("s1_start_e2", 64'(start20), 64'(0));

    // Scenario 2: 24-word template
    send_frame(1, 26, 25, 32'h12345678, 32'h9ABCDEF0, 32'hA000_0000);
    chk("s2_start_e0", 64'(start24), 64'(0));
    tick();
    chk("s2_start_e1", 64'(start24), 64'(1));
    chk("s2_threshold", threshold24, 64'h9ABCDEF0_12345678);
    chk("s2_tpl0", 64'(tpl24[0 +: 32]), 64'h0000_0000_A000_0002);
    chk("s2_tpl23", 64'(tpl24[32*23 +: 32]), 64'h0000_0000_A000_0019);
    tick();
    chk("s2_start_e2", 64'(start24), 64'(0));
    chk("s2_jobs", 64'(jobs_issued24), 64'(1));

    // Scenario 3: frame completes while scanner is busy
    scanner_ready = 1'b0;
    send_frame(0, 22, 21, 32'h11, 32'h22, 32'h100);
    for (int c = 0; c < 100; c++) begin
      chk("s3_pending", 64'(job_pending20), 64'(1));
      chk("s3_s_ready", 64'(s_ready20), 64'(0));
      chk("s3_no_start", 64'(start20), 64'(0));
      chk("s3_thr_held", threshold20, 64'h0000_0000_0000_FFFF);
      tick();
    end
    scanner_ready = 1'b1;
    tick();
    chk("s3_start", 64'(start20), 64'(1));
    chk("s3_threshold", threshold20, 64'h00000022_00000011);
    chk("s3_tpl0", 64'(tpl20[0 +: 32]), 64'h102);
    chk("s3_jobs", 64'(jobs_issued20), 64'(2));

    // Scenario 4: next frame streamed while job 2 scans
    scanner_ready = 1'b0;
    send_frame(0, 22, 21, 32'h33, 32'h44, 32'h200);
    repeat (5) tick();
    chk("s4_pending", 64'(job_pending20), 64'(1));
    chk("s4_thr_held", threshold20, 64'h00000022_00000011);
    chk("s4_tpl19_held", 64'(tpl20[32*19 +: 32]), 64'h115);
    chk("s4_jobs_held", 64'(jobs_issued20), 64'(2));
    scanner_ready = 1'b1;
    tick();
    chk("s4_start", 64'(start20), 64'(1));
    chk("s4_threshold", threshold20, 64'h00000044_00000033);
    chk("s4_tpl19", 64'(tpl20[32*19 +: 32]), 64'h215);
    chk("s4_jobs", 64'(jobs_issued20), 64'(3));
    tick();

    // Scenario 5: short frame, long frame, then a good frame
`ifdef SHA3_LOADER_ERRCNT_EN
    exp_err = 8'd1;
`else
    exp_err = 8'd0;
`endif
    seen = start_seen20;
    send_frame(0, 10, 9, 32'h1, 32'h2, 32'h400);
    tick();
    chk("s5_short_err", 64'(err_count20), 64'(exp_err));
    chk("s5_short_pending", 64'(job_pending20), 64'(0));
    send_frame(0, 31, 30, 32'h3, 32'h4, 32'h500);
    repeat (3) tick();
`ifdef SHA3_LOADER_ERRCNT_EN
    exp_err = 8'd2;
`endif
    chk("s5_long_err", 64'(err_count20), 64'(exp_err));
    chk("s5_long_pending", 64'(job_pending20), 64'(0));
    chk("s5_no_start", 64'(start_seen20), 64'(seen));
    chk("s5_thr_held", threshold20, 64'h00000044_00000033);
    send_frame(0, 22, 21, 32'h55, 32'h66, 32'h300);
    tick();
    chk("s5_start", 64'(start20), 64'(1));
    chk("s5_threshold", threshold20, 64'h00000066_00000055);
    chk("s5_tpl5", 64'(tpl20[32*5 +: 32]), 64'h307);
    chk("s5_jobs", 64'(jobs_issued20), 64'(4));
    tick();

    // Scenario 6: reset in the middle of a frame
    send_frame(0, 12, 99, 32'h77, 32'h88, 32'h600);
    rst_n = 1'b0;
    #2;
    chk("s6_start", 64'(start20), 64'(0));
    chk("s6_pending", 64'(job_pending20), 64'(0));
    chk("s6_threshold", threshold20, 64'(0));
    chk("s6_tpl0", 64'(tpl20[0 +: 32]), 64'(0));
    chk("s6_jobs", 64'(jobs_issued20), 64'(0));
    chk("s6_err", 64'(err_count20), 64'(0));
    #3 rst_n = 1'b1;
    seen = start_seen20;
    tick();
    chk("s6_s_ready", 64'(s_ready20), 64'(1));
    repeat (30) tick();
    chk("s6_no_start", 64'(start_seen20), 64'(seen));
    chk("s6_no_pending", 64'(job_pending20), 64'(0));
    send_frame(0, 22, 21, 32'h99, 32'hAA, 32'h700);
    tick();
    chk("s6_start_new", 64'(start20), 64'(1));
    chk("s6_jobs_new", 64'(jobs_issued20), 64'(1));
    chk("s6_thr_new", threshold20, 64'h000000AA_00000099);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
